// File: rtl/clasificador_boton_pkg.sv
// Shared constants and types for the button front end: debounce settings and the
// click classifier state encoding and default timings.
package clasificador_boton_pkg;

  // Debounce front end, 20 ms at 50 MHz
  localparam int unsigned DebounceCount      = 1_000_000;
  localparam int unsigned DebounceSyncStages = 2;

  // Classifier default timings at 50 MHz
  localparam int unsigned CountLargoDef = 50_000_000;
  localparam int unsigned CountRepDef   = 12_500_000;
  localparam int unsigned CountDobleDef = 15_000_000;

  typedef enum logic [2:0] {
    StReposo,
    StPresionado,
    StLargo,
    StEsperaDoble,
    StSegundo
  } estado_e;

  // Width able to hold (largest threshold - 1), never below 1 bit
  function automatic int unsigned ancho_contador(input int unsigned a, input int unsigned b,
                                                 input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/contador_umbral.sv
// Clearable up-counter that raises a terminal flag at a runtime threshold and
// holds there instead of wrapping.
module contador_umbral #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] umbral_i,
  output logic             tc_o
);

  logic [Width-1:0] cuenta_q, cuenta_d;

  assign tc_o = (cuenta_q == umbral_i);

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (en_i && !tc_o) begin
      cuenta_d = cuenta_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/clasificador_boton.sv
// Classifies a debounced button into single click, double click, long press and
// auto-repeat one-cycle events, all from one shared threshold counter.
module clasificador_boton
  import clasificador_boton_pkg::*;
#(
  parameter int unsigned COUNT_LARGO = CountLargoDef,
  parameter int unsigned COUNT_REP   = CountRepDef,
  parameter int unsigned COUNT_DOBLE = CountDobleDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_in,
  output logic presionado,
  output logic pulso_corto,
  output logic pulso_doble,
  output logic pulso_largo,
  output logic pulso_repeticion
);

  localparam int unsigned CntW = ancho_contador(COUNT_LARGO, COUNT_REP, COUNT_DOBLE);

  estado_e         estado_q, estado_d;
  logic            cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0] umbral;
  logic            corto_d, doble_d, largo_d, rep_d;

  contador_umbral #(
    .Width(CntW)
  ) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .umbral_i(umbral),
    .tc_o    (cnt_tc)
  );

  assign cnt_en = (estado_q != StReposo);

  // The threshold follows the state; every state change clears the counter.
  always_comb begin
    umbral = CntW'(COUNT_LARGO - 1);
    case (estado_q)
      StLargo:       umbral = CntW'(COUNT_REP - 1);
      StEsperaDoble: umbral = CntW'(COUNT_DOBLE - 1);
      default:       umbral = CntW'(COUNT_LARGO - 1);
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    cnt_clr  = 1'b0;
    corto_d  = 1'b0;
    doble_d  = 1'b0;
    largo_d  = 1'b0;
    rep_d    = 1'b0;
    case (estado_q)
      StReposo: begin
        cnt_clr = 1'b1;
        if (boton_in) estado_d = StPresionado;
      end
      StPresionado: begin
        if (!boton_in) begin
          estado_d = StEsperaDoble;
          cnt_clr  = 1'b1;
        end else if (cnt_tc) begin
          estado_d = StLargo;
          cnt_clr  = 1'b1;
          largo_d  = 1'b1;
        end
      end
      StLargo: begin
        if (!boton_in) begin
          estado_d = StReposo;
          cnt_clr  = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          rep_d   = 1'b1;
        end
      end
      StEsperaDoble: begin
        // A press on the timeout edge still counts as the second click
        if (boton_in) begin
          estado_d = StSegundo;
          cnt_clr  = 1'b1;
        end else if (cnt_tc) begin
          estado_d = StReposo;
          cnt_clr  = 1'b1;
          corto_d  = 1'b1;
        end
      end
      StSegundo: begin
        if (!boton_in) begin
          estado_d = StReposo;
          cnt_clr  = 1'b1;
          doble_d  = 1'b1;
        end else if (cnt_tc) begin
          estado_d = StLargo;
          cnt_clr  = 1'b1;
          largo_d  = 1'b1;
        end
      end
      default: begin
        estado_d = StReposo;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q         <= StReposo;
      presionado       <= 1'b0;
      pulso_corto      <= 1'b0;
      pulso_doble      <= 1'b0;
      pulso_largo      <= 1'b0;
      pulso_repeticion <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      presionado       <= boton_in;
      pulso_corto      <= corto_d;
      pulso_doble      <= doble_d;
      pulso_largo      <= largo_d;
      pulso_repeticion <= rep_d;
    end
  end

endmodule

// File: tb/tb_clasificador_boton.sv
// Scoreboard bench for clasificador_boton: each scenario queues the pulses it
// should cause, tagged with the clock edge they must follow.
module tb_clasificador_boton;

  localparam int unsigned LARGO = 20;
  localparam int unsigned REP   = 5;
  localparam int unsigned DOBLE = 8;

  localparam logic [3:0] P_CORTO = 4'b0001;
  localparam logic [3:0] P_DOBLE = 4'b0010;
  localparam logic [3:0] P_REP   = 4'b0100;
  localparam logic [3:0] P_LARGO = 4'b1000;

  typedef struct {
    logic [3:0]  kind;
    int unsigned cyc;
  } evento_t;

  evento_t sb[$];
  evento_t mon_ev;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boton_in = 1'b0;
  logic presionado, pulso_corto, pulso_doble, pulso_largo, pulso_repeticion;
  logic [3:0] pulses;

  int unsigned edge_n = 0;
  logic        prev_boton = 1'b0;
  logic        prev_valid = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned e0, r, e2;

  clasificador_boton #(
    .COUNT_LARGO(LARGO),
    .COUNT_REP  (REP),
    .COUNT_DOBLE(DOBLE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .boton_in        (boton_in),
    .presionado      (presionado),
    .pulso_corto     (pulso_corto),
    .pulso_doble     (pulso_doble),
    .pulso_largo     (pulso_largo),
    .pulso_repeticion(pulso_repeticion)
  );

  assign pulses = {pulso_largo, pulso_repeticion, pulso_doble, pulso_corto};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n     <= edge_n + 1;
    prev_boton <= boton_in;
    prev_valid <= rst_n;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic esperar(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic esperado(input logic [3:0] k, input int unsigned c);
    evento_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic fin_caso(input string tag);
    check_eq(tag, 32'(sb.size()), 0);
    sb.delete();
  endtask

  // Monitor: every pulse must match the head of the scoreboard in kind and edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid) check_eq("presionado_delay", 32'(presionado), 32'(prev_boton));
      if (pulses != 4'b0000) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 32'(pulses), 0);
        end else begin
          mon_ev = sb.pop_front();
          check_eq("pulse_kind", 32'(pulses), 32'(mon_ev.kind));
          check_eq("pulse_edge", edge_n, mon_ev.cyc);
        end
      end
    end
  end

  initial begin
    #12;
    check_eq("reset_pulses", 32'(pulses), 0);
    check_eq("reset_presionado", 32'(presionado), 0);
    esperar(1);
    rst_n = 1'b1;
    esperar(2);

    // Single click: press 6, release, corto 8 edges after release
    e0 = edge_n + 1;
    esperado(P_CORTO, e0 + 6 + DOBLE);
    boton_in = 1'b1; esperar(6);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_single");

    // Double click: press 4, release 3, press 4, release
    e0 = edge_n + 1;
    esperado(P_DOBLE, e0 + 11);
    boton_in = 1'b1; esperar(4);
    boton_in = 1'b0; esperar(3);
    boton_in = 1'b1; esperar(4);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_double");

    // Long hold of 32: largo at +20, repeats at +25 and +30
    e0 = edge_n + 1;
    esperado(P_LARGO, e0 + LARGO);
    esperado(P_REP, e0 + LARGO + REP);
    esperado(P_REP, e0 + LARGO + 2 * REP);
    boton_in = 1'b1; esperar(32);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_long");

    // Second press exactly on the timeout edge wins
    e0 = edge_n + 1;
    r  = e0 + 3;
    esperado(P_DOBLE, r + DOBLE + 3);
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(8);
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_press_at_timeout");

    // One edge late: corto fires, then the late press is a fresh click
    e0 = edge_n + 1;
    r  = e0 + 3;
    esperado(P_CORTO, r + DOBLE);
    esperado(P_CORTO, r + DOBLE + 1 + 3 + DOBLE);
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(9);
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(14);
    fin_caso("sb_press_after_timeout");

    // Second press held 25: largo from the second press, no double, no repeat
    e0 = edge_n + 1;
    e2 = e0 + 3 + 2;
    esperado(P_LARGO, e2 + LARGO);
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(2);
    boton_in = 1'b1; esperar(25);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_second_long");

    // Reset during the double-click wait drops the pending single click
    boton_in = 1'b1; esperar(3);
    boton_in = 1'b0; esperar(4);
    rst_n = 1'b0;
    #1;
    check_eq("reset_wait_pulses", 32'(pulses), 0);
    esperar(2);
    rst_n = 1'b1;
    esperar(14);
    fin_caso("sb_reset_wait");

    // Reset mid-hold at cycle 15, button kept down through reset
    boton_in = 1'b1; esperar(15);
    rst_n = 1'b0;
    #1;
    check_eq("reset_hold_presionado", 32'(presionado), 0);
    check_eq("reset_hold_pulses", 32'(pulses), 0);
    esperar(3);
    rst_n = 1'b1;
    e0 = edge_n + 1;
    esperado(P_LARGO, e0 + LARGO);
    esperar(23);
    boton_in = 1'b0; esperar(12);
    fin_caso("sb_reset_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clasificador_boton.md
CLASIFICADOR_BOTON -- requirements
Module: clasificador_boton

Interface
REQ-001 SHALL have parameter COUNT_LARGO, default 50_000_000: hold cycles before a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter COUNT_REP, default 12_500_000: cycles between auto-repeat pulses while held.
REQ-003 SHALL have parameter COUNT_DOBLE, default 15_000_000: cycles after release within which a second press counts as a double click.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port boton_in, input, 1 bit: debounced button level, 1 = pressed, synchronous to clk.
REQ-007 SHALL have port presionado, output, 1 bit: registered copy of boton_in.
REQ-008 SHALL have port pulso_corto, output, 1 bit: one-cycle single-click event.
REQ-009 SHALL have port pulso_doble, output, 1 bit: one-cycle double-click event.
REQ-010 SHALL have port pulso_largo, output, 1 bit: one-cycle long-press event.
REQ-011 SHALL have port pulso_repeticion, output, 1 bit: one-cycle auto-repeat event.

Function
REQ-012 SHALL implement FSM states REPOSO, PRESIONADO, LARGO, ESPERA_DOBLE, SEGUNDO, plus one shared counter sized $clog2 of the largest parameter.
REQ-013 In REPOSO, boton_in=1 SHALL move to PRESIONADO and clear the counter; this is edge E0.
REQ-014 In PRESIONADO, boton_in=0 before the threshold SHALL move to ESPERA_DOBLE and clear the counter; this is edge R.
REQ-015 In PRESIONADO, if held until counter = COUNT_LARGO-1, the FSM SHALL assert pulso_largo after edge E0+COUNT_LARGO, move to LARGO, and clear the counter.
REQ-016 In LARGO, the FSM SHALL assert pulso_repeticion after edges E0+COUNT_LARGO+k*COUNT_REP (k >= 1) while held; boton_in=0 SHALL return to REPOSO with no further pulse.
REQ-017 In ESPERA_DOBLE, boton_in=1 before counter = COUNT_DOBLE-1 SHALL move to SEGUNDO and clear the counter.
REQ-018 In ESPERA_DOBLE with no press, the FSM SHALL assert pulso_corto after edge R+COUNT_DOBLE and return to REPOSO.
REQ-019 If the press arrives on the same edge as the timeout, the press SHALL win: go to SEGUNDO, no pulso_corto.
REQ-020 In SEGUNDO, boton_in=0 SHALL assert pulso_doble after the edge that samples the release, then return to REPOSO.
REQ-021 In SEGUNDO, if held to COUNT_LARGO, the FSM SHALL assert pulso_largo, suppress the double click, and move to LARGO with repeat timing counted from the second press.
REQ-022 All pulse outputs SHALL be registered, exactly one cycle wide, and mutually exclusive.
REQ-023 The counter SHALL never wrap; it holds or clears as the state rules above dictate.
REQ-024 presionado SHALL equal boton_in delayed by one cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state REPOSO, counter 0, and all outputs 0, including during any press or wait.
REQ-026 After rst_n deasserts with boton_in already 1, the first active edge SHALL be treated as E0.

Structure
REQ-027 State encodings and default count constants SHALL live in the shared project include/package file, alongside the debounce constants.
REQ-028 A sub-module contador_umbral (load-clear counter with terminal-count flag) SHALL be used for the counter; everything else stays in clasificador_boton.

Verification (COUNT_LARGO=20, COUNT_REP=5, COUNT_DOBLE=8)
REQ-029 Press for 6 cycles, release, idle 10 cycles -> pulso_corto exactly once, 8 cycles after the release edge; no other pulses.
REQ-030 Press 4, release 3, press 4, release -> pulso_doble exactly once on the second release edge; no pulso_corto.
REQ-031 Hold for 32 cycles -> pulso_largo at E0+20, pulso_repeticion at E0+25 and E0+30; nothing after release.
REQ-032 Release, then press again exactly at R+8 -> SEGUNDO entered, no pulso_corto.
REQ-033 Press, release, then hold the second press for 25 cycles -> pulso_largo at second E0+20, no pulso_doble.
REQ-034 Assert rst_n=0 mid-hold at cycle 15 for 3 cycles with the button still held -> outputs 0 immediately, and pulso_largo 20 cycles after the first post-reset edge.
